muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit with HI/LO result registers; next generation of the single-cycle hilo path.
//  Sits in EX: accepts an op from EX, computes over multiple cycles, and holds results for MFHI/MFLO.
//  Exposes start/busy/done so the hazard unit can stall F/D/E while busy.
//  Width is parametrised; supports signed/unsigned multiply and divide.
// PARAMETERS
//  WIDTH     32   operand width; HI and LO are WIDTH bits each
//  CNT_W     6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk       in   1        clock, all state updates on rising edge
//  rst       in   1        synchronous active-high reset
//  start     in   1        request new op; sampled only in IDLE
//  op        in   2        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a         in   WIDTH    rs operand (multiplicand / dividend)
//  b         in   WIDTH    rt operand (multiplier / divisor)
//  cancel    in   1        pipeline flush; aborts op in flight
//  hilo_we   in   1        direct write (MTHI/MTLO) select, IDLE only
//  hilo_sel  in   1        0 = write LO, 1 = write HI
//  hilo_wd   in   WIDTH    data for direct write
//  busy      out  1        high from cycle after accepted start until done
//  done      out  1        one-cycle pulse when HI/LO updated by an op
//  hi        out  WIDTH    HI register (remainder / upper product)
//  lo        out  WIDTH    LO register (quotient / lower product)
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
//  States: IDLE -> MUL or DIV (start & ~cancel) -> FIX -> IDLE.
//  IDLE: on start latch |a|,|b| (abs only for signed ops), result signs, op; counter=0.
//  MUL: shift-add, one multiplier bit per cycle, WIDTH cycles; 2*WIDTH-bit accumulator.
//  DIV: restoring radix-2, one quotient bit per cycle, WIDTH cycles.
//  FIX: apply sign (product: sa^sb; quotient: sa^sb; remainder: sa); write hi/lo; done=1.
//  Latency: start in cycle T -> done in cycle T+WIDTH+2 (no early-out); hi/lo valid same edge.
//  busy=1 in MUL/DIV/FIX; busy=0 in IDLE. Hazard unit stalls on (start | busy) & ~done.
//  start while busy: ignored, no queuing. hilo_we while busy: ignored.
//  hilo_we in IDLE with start same cycle: direct write performed, start still accepted.
//  Divide by zero: completes with normal latency; lo = all ones, hi = a (raw operand).
//  Signed DIV most-negative / -1: lo = most-negative, hi = 0 (wraps naturally).
//  cancel in MUL/DIV/FIX: next state IDLE, no done, hi/lo keep prior values.
//  cancel in IDLE with start: cancel wins, op not accepted.
//  rst mid-operation: behaves as reset; partial results discarded.
//  Products/quotients are truncated to 2*WIDTH bits; no overflow flag.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined: MUL exits to FIX when remaining multiplier bits are all zero;
//    DIV by zero exits to FIX after 1 cycle. Result values identical; only latency shrinks.
//  Undefined: every op takes exactly WIDTH iteration cycles; latency fixed at WIDTH+2.
// STRUCTURE
//  Shared header muldiv_defs.vh: op encodings (OP_MULT..OP_DIVU), state codes (S_IDLE,
//    S_MUL, S_DIV, S_FIX); also included by the control unit and the hazard unit.
//  One sub-module: div_step, combinational restoring step (partial remainder, divisor ->
//    next remainder, quotient bit); instantiated once, reused each cycle.
// TESTING
//  MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at T+34; hi=0xFFFFFFFE lo=0x00000001.
//  MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; busy high cycles T+1..T+33.
//  DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> lo=0xFFFFFFFF hi=7.
//  DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0; second start mid-op ignored.
//  MULTU started, cancel at T+10 -> no done, busy=0 at T+11, hi/lo equal pre-start values.
//  With MULDIV_EARLY_OUT_EN: MULTU a=5 b=3 -> done by T+4, hi=0 lo=15; rst at T+2 clears all.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: op encodings, FSM state codes and op decode helpers
// shared by the multiply/divide unit, the control unit and the hazard unit.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } opType;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_FIX  = 2'b11
    } stateType;

    function automatic logic isSignedOp(input logic [1:0] op);
        return !op[0];
    endfunction

    function automatic logic isDivOp(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: EX-stage request, direct HI/LO write and result bundle
// between the pipeline (master) and the multiply/divide unit (slave).
interface muldiv_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             hilo_we;
    logic             hilo_sel;
    logic [WIDTH-1:0] hilo_wd;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, cancel, hilo_we, hilo_sel, hilo_wd,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel, hilo_we, hilo_sel, hilo_wd,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit_div_step.sv
// div_step: one combinational restoring-division step producing the next
// partial remainder and one quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             inBit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] nextRem,
    output logic             qBit
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // rem < divisor always holds, so a successful subtract fits in WIDTH bits
    assign shifted = {rem, inBit};
    assign diff    = shifted[WIDTH-1:0] - divisor;
    assign qBit    = shifted >= {1'b0, divisor};
    assign nextRem = qBit ? diff : shifted[WIDTH-1:0];
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply/divide with HI/LO registers.
// Define MULDIV_EARLY_OUT_EN to end MUL/DIV iterations early when the result is already known.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    stateType           state, stateNext;
    logic [CNT_W-1:0]   counter;
    logic [2*WIDTH-1:0] acc, mcand, mulRes;
    logic [WIDTH-1:0]   mplier, rem, quo, divisor, aRaw, hiReg, loReg;
    logic [WIDTH-1:0]   absA, absB, remNext, quoRes, remRes;
    logic               negRes, negRem, bZero, isDiv, doneReg;
    logic               sa, sb, qBit, lastIter, mulLast, divLast;

    assign sa       = isSignedOp(bus.op) & bus.a[WIDTH-1];
    assign sb       = isSignedOp(bus.op) & bus.b[WIDTH-1];
    assign absA     = sa ? -bus.a : bus.a;
    assign absB     = sb ? -bus.b : bus.b;
    assign lastIter = counter == CNT_W'(WIDTH - 1);
    assign mulRes   = negRes ? -acc : acc;
    assign quoRes   = negRes ? -quo : quo;
    assign remRes   = negRem ? -rem : rem;

`ifdef MULDIV_EARLY_OUT_EN
    assign mulLast = lastIter | ~|mplier[WIDTH-1:1];
    assign divLast = lastIter | bZero;
`else
    assign mulLast = lastIter;
    assign divLast = lastIter;
`endif

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem    (rem),
        .inBit  (quo[WIDTH-1]),
        .divisor(divisor),
        .nextRem(remNext),
        .qBit   (qBit)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        if (bus.cancel) stateNext = S_IDLE;
        else begin
            case (state)
                S_IDLE: stateNext = bus.start ? (isDivOp(bus.op) ? S_DIV : S_MUL) : S_IDLE;
                S_MUL:  stateNext = mulLast ? S_FIX : S_MUL;
                S_DIV:  stateNext = divLast ? S_FIX : S_DIV;
                S_FIX:  stateNext = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            aRaw    <= '0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            bZero   <= 1'b0;
            isDiv   <= 1'b0;
            hiReg   <= '0;
            loReg   <= '0;
            doneReg <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.hilo_we) begin
                        if (bus.hilo_sel) hiReg <= bus.hilo_wd;
                        else              loReg <= bus.hilo_wd;
                    end
                    if (bus.start & ~bus.cancel) begin
                        counter <= '0;
                        acc     <= '0;
                        mcand   <= {{WIDTH{1'b0}}, absA};
                        mplier  <= absB;
                        rem     <= '0;
                        quo     <= absA;
                        divisor <= absB;
                        aRaw    <= bus.a;
                        negRes  <= sa ^ sb;
                        negRem  <= sa;
                        bZero   <= bus.b == '0;
                        isDiv   <= isDivOp(bus.op);
                    end
                end
                S_MUL: begin
                    acc     <= acc + (mplier[0] ? mcand : '0);
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    counter <= counter + CNT_W'(1);
                end
                S_DIV: begin
                    rem     <= remNext;
                    quo     <= {quo[WIDTH-2:0], qBit};
                    counter <= counter + CNT_W'(1);
                end
                S_FIX: begin
                    if (!bus.cancel) begin
                        doneReg <= 1'b1;
                        // divide by zero reports the raw dividend, not its magnitude
                        {hiReg, loReg} <= isDiv ? (bZero ? {aRaw, {WIDTH{1'b1}}} : {remRes, quoRes}) : mulRes;
                    end
                end
            endcase
        end
    end

    assign bus.busy = state != S_IDLE;
    assign bus.done = doneReg;
    assign bus.hi   = hiReg;
    assign bus.lo   = loReg;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit; expected HI/LO and done
// cycle are queued at issue and compared whenever done pulses.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           due;
    } entryType;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    int       cyc = 0;
    int       nChecks = 0;
    int       nErrors = 0;
    entryType sb[$];

    muldiv_unit_if #(.WIDTH(W)) bus();

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic         na, nb;
        logic [63:0]  ua, ub, p, q, r;
        logic [W-1:0] qq, rr;
        na = isSignedOp(op) & a[W-1];
        nb = isSignedOp(op) & b[W-1];
        ua = {32'b0, na ? -a : a};
        ub = {32'b0, nb ? -b : b};
        if (!isDivOp(op)) begin
            p = ua * ub;
            return (na ^ nb) ? -p : p;
        end
        if (b == '0) return {a, {W{1'b1}}};
        q  = ua / ub;
        r  = ua % ub;
        qq = (na ^ nb) ? -q[W-1:0] : q[W-1:0];
        rr = na ? -r[W-1:0] : r[W-1:0];
        return {rr, qq};
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) check("spurious_done", {63'b0, bus.done}, 64'd0);
            else begin
                entryType e;
                e = sb.pop_front();
                check("hi", bus.hi, e.hi);
                check("lo", bus.lo, e.lo);
`ifdef MULDIV_EARLY_OUT_EN
                check("done_late", {63'b0, cyc > e.due}, 64'd0);
`else
                check("done_cycle", cyc, e.due);
`endif
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input int lat);
        logic [63:0] r;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (push) begin
            r = model(op, a, b);
            sb.push_back('{r[63:32], r[31:0], cyc + lat});
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        check("drain", sb.size(), 64'd0);
        repeat (2) @(posedge clk);
    endtask

    task automatic hiloWrite(input logic sel, input logic [W-1:0] wd);
        @(posedge clk); #1;
        bus.hilo_we  = 1'b1;
        bus.hilo_sel = sel;
        bus.hilo_wd  = wd;
        @(posedge clk); #1;
        bus.hilo_we = 1'b0;
        @(negedge clk);
        check(sel ? "mthi" : "mtlo", sel ? bus.hi : bus.lo, wd);
    endtask

    initial begin
        bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.cancel = 0;
        bus.hilo_we = 0; bus.hilo_sel = 0; bus.hilo_wd = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        @(posedge clk); #1 rst = 1'b0;

        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, LAT);
        drain();

        issue(OP_MULT, 32'hFFFFFFFD, 32'd7, 1, LAT);
`ifndef MULDIV_EARLY_OUT_EN
        @(negedge clk);
        check("busy_t1", bus.busy, 1);
        repeat (32) @(negedge clk);
        check("busy_t33", bus.busy, 1);
        @(negedge clk);
        check("busy_t34", bus.busy, 0);
`endif
        drain();

        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1, LAT);
        drain();
        issue(OP_DIVU, 32'd7, 32'd0, 1, LAT);
        drain();

        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1, LAT);
        repeat (4) @(posedge clk); #1;
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 3; bus.b = 3;
        bus.hilo_we = 1'b1; bus.hilo_sel = 1'b1; bus.hilo_wd = 32'hDEADBEEF;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.hilo_we = 1'b0;
        @(negedge clk);
        check("hi_write_busy", bus.hi, 32'd7);
        drain();

        hiloWrite(1'b1, 32'hAAAA0000);
        hiloWrite(1'b0, 32'h0000BBBB);

        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 9; bus.b = 32'h80000000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk); #1;
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        @(negedge clk);
        check("cancel_busy", bus.busy, 0);
        repeat (40) @(posedge clk);
        check("cancel_hi", bus.hi, 32'hAAAA0000);
        check("cancel_lo", bus.lo, 32'h0000BBBB);

        @(posedge clk); #1;
        bus.start = 1'b1; bus.cancel = 1'b1; bus.op = OP_MULTU; bus.a = 2; bus.b = 2;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cancel = 1'b0;
        @(negedge clk);
        check("idle_cancel_busy", bus.busy, 0);
        repeat (40) @(posedge clk);

        @(posedge clk); #1;
        bus.hilo_we = 1'b1; bus.hilo_sel = 1'b0; bus.hilo_wd = 32'h55;
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 6; bus.b = 7;
        sb.push_back('{32'd0, 32'd42, cyc + LAT});
        @(posedge clk); #1;
        bus.hilo_we = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        check("we_start_lo", bus.lo, 32'h55);
        check("we_start_busy", bus.busy, 1);
        drain();

`ifdef MULDIV_EARLY_OUT_EN
        issue(OP_MULTU, 32'd5, 32'd3, 1, 4);
        drain();
`endif

        for (int i = 0; i < 8; i++) begin
            logic [1:0]   op;
            logic [W-1:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
            issue(op, a, b, 1, LAT);
            drain();
        end

        issue(OP_MULTU, 32'd9, 32'h80000000, 0, LAT);
        repeat (3) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", bus.busy, 0);
        check("midrst_hi", bus.hi, 0);
        check("midrst_lo", bus.lo, 0);
        repeat (40) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
